// File: rtl/lc3b_mem_stage_seq.sv
// rtl/lc3b_mem_stage_seq.sv - ME-stage memory sequencer: direct/indirect loads and stores
// with a posted store buffer that drains to the dcache when the port is idle.
module lc3b_mem_stage_seq #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int BE_W     = 2,
    parameter int SB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    input  logic [1:0]                  req_kind,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [BE_W-1:0]             req_be,
    input  logic                        advance,
    input  logic                        drain_req,
    output logic                        stall,
    output logic                        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        dc_req,
    output logic                        dc_we,
    output logic [ADDR_W-1:0]           dc_addr,
    output logic [DATA_W-1:0]           dc_wdata,
    output logic [BE_W-1:0]             dc_be,
    input  logic                        dc_resp,
    input  logic [DATA_W-1:0]           dc_rdata,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_full,
    output logic                        sb_empty
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam logic [1:0] K_LD = 2'b00, K_ST = 2'b01, K_LDI = 2'b10, K_STI = 2'b11;

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sb_addr [SB_DEPTH];
    logic [DATA_W-1:0]   sb_data [SB_DEPTH];
    logic [BE_W-1:0]     sb_be   [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_valid;
    logic [PTR_W-1:0]    head, tail;
    logic [ADDR_W-1:0]   ptr;
    logic                ptr_ok, op_done;
    logic [DATA_W-1:0]   rdata_q;

    logic [BE_W-1:0]     issue_be;
    logic                hz_req, hz_ptr, rd_go, st_try, push, pop, ld_fin, fin, done_n;
    logic [ADDR_W-1:0]   st_addr;

    assign sb_full  = (sb_count == (PTR_W+1)'(SB_DEPTH));
    assign sb_empty = (sb_count == '0);

    // Pointer reads fetch a full word, so they hazard against any byte of it.
    assign issue_be = (req_kind == K_LD) ? req_be : '1;

    always_comb begin
        hz_req = 1'b0;
        hz_ptr = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i] && sb_addr[i][ADDR_W-1:1] == req_addr[ADDR_W-1:1]
                && (sb_be[i] & issue_be) != '0)
                hz_req = 1'b1;
            if (sb_valid[i] && sb_addr[i][ADDR_W-1:1] == ptr[ADDR_W-1:1]
                && (sb_be[i] & req_be) != '0)
                hz_ptr = 1'b1;
        end
    end

    assign rd_go  = req_valid && !op_done && !ptr_ok && req_kind != K_ST
                    && !hz_req && !(drain_req && !sb_empty);
    assign st_try = req_valid && !op_done &&
                    (((state == IDLE || state == WR) &&
                      (req_kind == K_ST || (req_kind == K_STI && ptr_ok))) ||
                     (state == RD1 && dc_resp && req_kind == K_STI));
    assign pop     = (state == WR) && dc_resp;
    assign push    = st_try && (!sb_full || pop);
    assign st_addr = (state == RD1) ? ADDR_W'(dc_rdata) :
                     (req_kind == K_STI) ? ptr : req_addr;
    assign ld_fin  = dc_resp && ((state == RD1 && req_kind == K_LD) || (state == RD2 && dc_req));
    assign fin     = push || ld_fin;
    assign done_n  = !advance && (op_done || fin);

    assign resp_valid = op_done || fin;
    assign resp_rdata = ld_fin ? dc_rdata : rdata_q;
    assign stall      = req_valid && !resp_valid;

    // Entry payload needs no reset; validity is tracked by sb_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= st_addr;
            sb_data[tail] <= req_wdata;
            sb_be[tail]   <= req_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dc_req   <= 1'b0;
            dc_we    <= 1'b0;
            dc_addr  <= '0;
            dc_wdata <= '0;
            dc_be    <= '0;
            head     <= '0;
            tail     <= '0;
            sb_count <= '0;
            sb_valid <= '0;
            ptr      <= '0;
            ptr_ok   <= 1'b0;
            op_done  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            op_done <= done_n;
            if (ld_fin)
                rdata_q <= dc_rdata;
            // Pop before push so a full-buffer swap on the same slot stays valid.
            if (pop) begin
                sb_valid[head] <= 1'b0;
                head <= head + 1'b1;
            end
            if (push) begin
                sb_valid[tail] <= 1'b1;
                tail <= tail + 1'b1;
            end
            if (push && !pop)
                sb_count <= sb_count + 1'b1;
            else if (pop && !push)
                sb_count <= sb_count - 1'b1;

            if (fin)
                ptr_ok <= 1'b0;
            else if (state == RD1 && dc_resp && req_kind[1]) begin
                ptr    <= ADDR_W'(dc_rdata);
                ptr_ok <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (rd_go) begin
                        state    <= RD1;
                        dc_req   <= 1'b1;
                        dc_we    <= 1'b0;
                        dc_addr  <= req_addr;
                        dc_wdata <= '0;
                        dc_be    <= issue_be;
                    end else if (!sb_empty) begin
                        state    <= WR;
                        dc_req   <= 1'b1;
                        dc_we    <= 1'b1;
                        dc_addr  <= sb_addr[head];
                        dc_wdata <= sb_data[head];
                        dc_be    <= sb_be[head];
                    end else begin
                        state <= done_n ? DONE : IDLE;
                    end
                end
                RD1: begin
                    if (dc_resp) begin
                        dc_req <= 1'b0;
                        if (req_kind == K_LDI)
                            state <= RD2;
                        else
                            state <= done_n ? DONE : IDLE;
                    end
                end
                RD2: begin
                    if (!dc_req) begin
                        // A hazard on the pointer target is resolved by draining the head.
                        if (!hz_ptr) begin
                            dc_req   <= 1'b1;
                            dc_we    <= 1'b0;
                            dc_addr  <= ptr;
                            dc_wdata <= '0;
                            dc_be    <= req_be;
                        end else begin
                            state    <= WR;
                            dc_req   <= 1'b1;
                            dc_we    <= 1'b1;
                            dc_addr  <= sb_addr[head];
                            dc_wdata <= sb_data[head];
                            dc_be    <= sb_be[head];
                        end
                    end else if (dc_resp) begin
                        dc_req <= 1'b0;
                        state  <= done_n ? DONE : IDLE;
                    end
                end
                WR: begin
                    if (dc_resp) begin
                        dc_req <= 1'b0;
                        dc_we  <= 1'b0;
                        if (ptr_ok && req_valid && req_kind == K_LDI)
                            state <= RD2;
                        else
                            state <= done_n ? DONE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3b_mem_stage_seq.sv
// tb/tb_lc3b_mem_stage_seq.sv - scoreboard bench for lc3b_mem_stage_seq
module tb_lc3b_mem_stage_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, advance, drain_req;
    logic [1:0]  req_kind;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  req_be;
    logic        stall, resp_valid;
    logic [15:0] resp_rdata;
    logic        dc_req, dc_we, dc_resp;
    logic [15:0] dc_addr, dc_wdata, dc_rdata;
    logic [1:0]  dc_be;
    logic [2:0]  sb_count;
    logic        sb_full, sb_empty;

    lc3b_mem_stage_seq dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_kind(req_kind),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .advance(advance),
        .drain_req(drain_req), .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_be(dc_be),
        .dc_resp(dc_resp), .dc_rdata(dc_rdata), .sb_count(sb_count), .sb_full(sb_full),
        .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] kind; logic [15:0] data; } resp_t;
    resp_t       exp_resp [$];
    logic [34:0] exp_dc   [$];
    logic [15:0] mem [int];
    int          n_vec = 0, n_mis = 0, viol = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] dcw(input logic we, input logic [1:0] be, input logic [15:0] a, input logic [15:0] d);
        return {we, be, a, we ? d : 16'h0};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(int'(a[15:1])) ? mem[int'(a[15:1])] : 16'h0;
    endfunction

    // dcache model: fixed latency, one outstanding access
    int   dc_lat = 1, dc_cnt = 0;
    logic dc_busy = 1'b0;
    always @(posedge clk) begin
        logic [15:0] w;
        #1;
        dc_resp = 1'b0;
        if (!rst_n) begin
            dc_busy = 1'b0;
        end else if (dc_busy) begin
            if (dc_cnt == 0) begin
                dc_busy = 1'b0;
                dc_resp = 1'b1;
                w = mem_rd(dc_addr);
                if (dc_we) begin
                    if (dc_be[0]) w[7:0]  = dc_wdata[7:0];
                    if (dc_be[1]) w[15:8] = dc_wdata[15:8];
                    mem[int'(dc_addr[15:1])] = w;
                end else begin
                    dc_rdata = w;
                end
            end else begin
                dc_cnt--;
            end
        end else if (dc_req) begin
            dc_busy = 1'b1;
            dc_cnt  = dc_lat - 1;
        end
    end

    // Monitor: dcache access order, retired responses, port stability
    logic        p_req = 1'b0, p_resp = 1'b0;
    logic [34:0] p_fields = '0, m_d;
    resp_t       m_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dc_req && !p_req) begin
                m_d = (exp_dc.size() > 0) ? exp_dc.pop_front() : 35'h7_FFFF_FFFF;
                chk("dc_seq", dcw(dc_we, dc_be, dc_addr, dc_wdata), m_d);
            end
            if (req_valid && resp_valid && advance) begin
                m_e = (exp_resp.size() > 0) ? exp_resp.pop_front() : '{kind: 3'b100, data: 16'h0};
                chk("rsp_kind", {1'b0, req_kind}, m_e.kind);
                if (m_e.kind == 3'b000 || m_e.kind == 3'b010)
                    chk("rsp_data", resp_rdata, m_e.data);
            end
            if (p_req && !p_resp && (!dc_req || {dc_we, dc_be, dc_addr, dc_wdata} != p_fields))
                viol++;
            if (p_resp && dc_req)
                viol++;
        end
        p_req    = dc_req && rst_n;
        p_resp   = dc_resp;
        p_fields = {dc_we, dc_be, dc_addr, dc_wdata};
    end

    task automatic start_op(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] be, input logic [15:0] exp_data);
        @(posedge clk); #1;
        req_valid = 1'b1; req_kind = k; req_addr = a; req_wdata = d; req_be = be;
        exp_resp.push_back('{kind: {1'b0, k}, data: exp_data});
    endtask

    task automatic wait_resp(output int cyc);
        cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) chk("resp_timeout", resp_valid, 1);
    endtask

    task automatic end_op();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic settle();
        int ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb_empty && !dc_req && !dc_busy && !dc_resp) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("settle", sb_empty, 1);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; req_valid = 1'b0; req_kind = 2'b00; req_addr = '0; req_wdata = '0;
        req_be = 2'b11; advance = 1'b1; drain_req = 1'b0; dc_resp = 1'b0; dc_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {dc_req, dc_we, resp_valid, stall, sb_full, sb_empty, sb_count}, 9'b000001_000);
        chk("rst_data", {dc_addr, dc_wdata, dc_be, resp_rdata}, 50'h0);
        rst_n = 1'b1;

        // 1: posted store, then unrelated load gets the port first
        mem[16'h2000 >> 1] = 16'h1111;
        exp_dc.push_back(dcw(0, 2'b11, 16'h2000, 0));
        exp_dc.push_back(dcw(1, 2'b11, 16'h1000, 16'hBEEF));
        start_op(2'b01, 16'h1000, 16'hBEEF, 2'b11, 0);
        wait_resp(c);
        chk("t1_st_lat", c, 0);
        start_op(2'b00, 16'h2000, 0, 2'b11, 16'h1111);
        @(negedge clk);
        chk("t1_cnt", sb_count, 1);
        wait_resp(c);
        end_op();
        settle();
        chk("t1_mem", mem_rd(16'h1000), 16'hBEEF);

        // 2: load hits buffered store, waits for the drain
        mem[16'h1000 >> 1] = 16'h0000;
        exp_dc.push_back(dcw(1, 2'b11, 16'h1000, 16'hBEEF));
        exp_dc.push_back(dcw(0, 2'b11, 16'h1000, 0));
        start_op(2'b01, 16'h1000, 16'hBEEF, 2'b11, 0);
        wait_resp(c);
        start_op(2'b00, 16'h1000, 0, 2'b11, 16'hBEEF);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dc_resp && dc_we) chk("t2_stall", stall, 1);
            if (resp_valid) begin
                c = i;
                break;
            end
        end
        if (c < 0) chk("t2_timeout", resp_valid, 1);
        end_op();
        settle();

        // 3: fill the buffer behind a slow drain
        dc_lat = 10;
        for (int i = 0; i < 5; i++)
            exp_dc.push_back(dcw(1, 2'b11, 16'h1100 + 16'(2 * i), 16'hA000 + 16'(i)));
        for (int i = 0; i < 4; i++) begin
            start_op(2'b01, 16'h1100 + 16'(2 * i), 16'hA000 + 16'(i), 2'b11, 0);
            wait_resp(c);
            chk("t3_lat", c, 0);
        end
        start_op(2'b01, 16'h1108, 16'hA004, 2'b11, 0);
        @(negedge clk);
        chk("t3_full", {sb_full, stall}, 2'b11);
        wait_resp(c);
        chk("t3_pop_same", {dc_resp, dc_we}, 2'b11);
        end_op();
        @(negedge clk);
        chk("t3_cnt", sb_count, 4);
        settle();
        dc_lat = 1;

        // 4: load-indirect
        mem[16'h3000 >> 1] = 16'h4000;
        mem[16'h4000 >> 1] = 16'h1234;
        exp_dc.push_back(dcw(0, 2'b11, 16'h3000, 0));
        exp_dc.push_back(dcw(0, 2'b11, 16'h4000, 0));
        start_op(2'b10, 16'h3000, 0, 2'b11, 16'h1234);
        wait_resp(c);
        chk("t4_edge", {dc_resp, stall}, 2'b10);
        end_op();
        settle();

        // 5: store-indirect held in DONE by advance=0
        advance = 1'b0;
        exp_dc.push_back(dcw(0, 2'b11, 16'h3000, 0));
        exp_dc.push_back(dcw(1, 2'b11, 16'h4000, 16'h5A5A));
        start_op(2'b11, 16'h3000, 16'h5A5A, 2'b11, 0);
        wait_resp(c);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold", {resp_valid, stall}, 2'b10);
        end
        @(posedge clk); #1;
        advance = 1'b1;
        end_op();
        @(negedge clk);
        chk("t5_idle", resp_valid, 0);
        settle();
        chk("t5_mem", mem_rd(16'h4000), 16'h5A5A);

        // 7: STB x1001 does not block LDB x1000
        exp_dc.push_back(dcw(0, 2'b01, 16'h1000, 0));
        exp_dc.push_back(dcw(1, 2'b10, 16'h1001, 16'h7700));
        start_op(2'b01, 16'h1001, 16'h7700, 2'b10, 0);
        wait_resp(c);
        start_op(2'b00, 16'h1000, 0, 2'b01, 16'hBEEF);
        wait_resp(c);
        end_op();
        settle();
        chk("t7_mem", mem_rd(16'h1000), 16'h77EF);

        // 8: drain_req fences an unrelated load
        drain_req = 1'b1;
        exp_dc.push_back(dcw(1, 2'b11, 16'h1200, 16'h2222));
        exp_dc.push_back(dcw(0, 2'b11, 16'h2000, 0));
        start_op(2'b01, 16'h1200, 16'h2222, 2'b11, 0);
        wait_resp(c);
        start_op(2'b00, 16'h2000, 0, 2'b11, 16'h1111);
        wait_resp(c);
        end_op();
        drain_req = 1'b0;
        settle();

        // 6: reset in the middle of a drain write
        dc_lat = 10;
        exp_dc.push_back(dcw(1, 2'b11, 16'h1300, 16'hCAFE));
        start_op(2'b01, 16'h1300, 16'hCAFE, 2'b11, 0);
        wait_resp(c);
        end_op();
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dc_req && dc_we) begin
                c = i;
                break;
            end
        end
        if (c < 0) chk("t6_wr", dc_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst", {dc_req, sb_empty, resp_valid, sb_count}, 6'b010_000);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dc_lat = 1;
        exp_dc.push_back(dcw(0, 2'b11, 16'h2000, 0));
        start_op(2'b00, 16'h2000, 0, 2'b11, 16'h1111);
        wait_resp(c);
        end_op();
        settle();
        chk("t6_nowr", mem_rd(16'h1300), 16'h0000);

        chk("port_rule", viol, 0);
        chk("dc_left", exp_dc.size(), 0);
        chk("rsp_left", exp_resp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
